// File: rtl/float_add_norm.sv
// ============================================================================
// Module      : float_add_norm
// Description : Post-add renormalization for the floating-point adder.
//               Takes the raw 48-bit coefficient sum, its carry-out, the
//               pre-normalize exponent and the leading-zero count, then
//               applies the normalizing shift and exponent correction over a
//               fixed two-stage pipeline with no backpressure.
//               Optional build macro: FLOAT_NORM_UFLOW_FLUSH_EN
//                 defined   -> underflowed results flush to true zero
//                 undefined -> underflowed results pass through, flag only
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_add_norm #(
    parameter int               EXP_W     = 15,
    parameter logic [EXP_W-1:0] UFLOW_LIM = 15'o20000,
    parameter logic [EXP_W-1:0] OFLOW_LIM = 15'o60000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_carry,
    input  logic [47:0]      i_coef,
    input  logic [6:0]       i_lzc,
    input  logic [2:0]       i_tag,
    output logic             o_valid,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [47:0]      o_coef,
    output logic [2:0]       o_tag,
    output logic             o_zero,
    output logic             o_uflow,
    output logic             o_oflow
);

    // Path encoding carried from stage 1 into stage 2.
    localparam logic [1:0] c_PATH_NORM  = 2'd0;
    localparam logic [1:0] c_PATH_CARRY = 2'd1;
    localparam logic [1:0] c_PATH_ZERO  = 2'd2;

    // ------------------------------------------------------------------
    // Stage 1 : path select and coarse (byte) shift
    // ------------------------------------------------------------------
    logic             w_is_zero;
    logic [5:0]       w_coarse_amt;
    logic [47:0]      w_coarse_coef;
    logic [1:0]       w_path;
    logic [47:0]      w_s1_coef;
    logic [5:0]       w_s1_lzc;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [47:0]      r_s1_coef;
    logic [5:0]       r_s1_lzc;
    logic [2:0]       r_s1_tag;
    logic [1:0]       r_s1_path;

    // Choose the path and perform the multiple-of-8 part of the left shift.
    always_comb begin
        w_is_zero     = !i_carry && (i_lzc >= 7'd48);
        w_coarse_amt  = {i_lzc[5:3], 3'b000};
        w_coarse_coef = i_coef << w_coarse_amt;
        w_path        = c_PATH_NORM;
        w_s1_coef     = w_coarse_coef;
        w_s1_lzc      = i_lzc[5:0];
        if (i_carry) begin
            // Carry-out becomes the new leading one; shift right by one.
            w_path    = c_PATH_CARRY;
            w_s1_coef = {1'b1, i_coef[47:1]};
            w_s1_lzc  = 6'd0;
        end else if (w_is_zero) begin
            w_path    = c_PATH_ZERO;
            w_s1_coef = 48'd0;
            w_s1_lzc  = 6'd0;
        end
    end

    // Stage 1 register: valid shifts every cycle, data loads only on valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_coef  <= 48'd0;
            r_s1_lzc   <= 6'd0;
            r_s1_tag   <= 3'd0;
            r_s1_path  <= c_PATH_NORM;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_sign <= i_sign;
                r_s1_exp  <= i_exp;
                r_s1_coef <= w_s1_coef;
                r_s1_lzc  <= w_s1_lzc;
                r_s1_tag  <= i_tag;
                r_s1_path <= w_path;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 : fine shift, exponent correction, range flags
    // ------------------------------------------------------------------
    logic [47:0]      w_fine_coef;
    logic [EXP_W:0]   w_exp_ext;
    logic [EXP_W-1:0] w_exp_lo;
    logic             w_exp_hi;
    logic             w_borrow;
    logic             w_cout;
    logic             w_s2_zero_path;
    logic             w_uflow;
    logic             w_oflow;
    logic             w_flush;
    logic             w_res_zero;

    // Finish the shift and compute the corrected exponent one bit wider so
    // that both borrow (negative) and carry past EXP_W bits are visible.
    always_comb begin
        w_fine_coef    = r_s1_coef << r_s1_lzc[2:0];
        w_s2_zero_path = (r_s1_path == c_PATH_ZERO);
        if (r_s1_path == c_PATH_CARRY) begin
            w_exp_ext = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            w_exp_ext = {1'b0, r_s1_exp} - {{(EXP_W-5){1'b0}}, r_s1_lzc};
        end
        w_exp_hi = w_exp_ext[EXP_W];
        w_exp_lo = w_exp_ext[EXP_W-1:0];
        // The extra bit means borrow on the subtract path, carry on increment.
        w_borrow = w_exp_hi && (r_s1_path == c_PATH_NORM);
        w_cout   = w_exp_hi && (r_s1_path == c_PATH_CARRY);
        w_uflow  = !w_s2_zero_path && !w_cout &&
                   (w_borrow || (w_exp_lo < UFLOW_LIM));
        w_oflow  = !w_s2_zero_path && !w_borrow &&
                   (w_cout || (w_exp_lo >= OFLOW_LIM));
`ifdef FLOAT_NORM_UFLOW_FLUSH_EN
        w_flush = w_uflow;
`else
        w_flush = 1'b0;
`endif
        w_res_zero = w_s2_zero_path || w_flush;
    end

    logic             r_o_valid;
    logic             r_o_sign;
    logic [EXP_W-1:0] r_o_exp;
    logic [47:0]      r_o_coef;
    logic [2:0]       r_o_tag;
    logic             r_o_zero;
    logic             r_o_uflow;
    logic             r_o_oflow;

    // Output register: valid shifts every cycle, data holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_sign  <= 1'b0;
            r_o_exp   <= '0;
            r_o_coef  <= 48'd0;
            r_o_tag   <= 3'd0;
            r_o_zero  <= 1'b0;
            r_o_uflow <= 1'b0;
            r_o_oflow <= 1'b0;
        end else begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o_tag   <= r_s1_tag;
                r_o_zero  <= w_res_zero;
                r_o_uflow <= w_uflow;
                r_o_oflow <= w_oflow;
                if (w_res_zero) begin
                    r_o_sign <= 1'b0;
                    r_o_exp  <= '0;
                    r_o_coef <= 48'd0;
                end else begin
                    r_o_sign <= r_s1_sign;
                    r_o_exp  <= w_exp_lo;
                    r_o_coef <= w_fine_coef;
                end
            end
        end
    end

    assign o_valid = r_o_valid;
    assign o_sign  = r_o_sign;
    assign o_exp   = r_o_exp;
    assign o_coef  = r_o_coef;
    assign o_tag   = r_o_tag;
    assign o_zero  = r_o_zero;
    assign o_uflow = r_o_uflow;
    assign o_oflow = r_o_oflow;

endmodule

`default_nettype wire

// File: tb/tb_float_add_norm.sv
// ============================================================================
// Module      : tb_float_add_norm
// Description : Scoreboard bench for float_add_norm. Directed vectors push
//               hand-computed results; a monitor pops and compares on o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_add_norm;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_sign;
    logic [14:0] i_exp;
    logic        i_carry;
    logic [47:0] i_coef;
    logic [6:0]  i_lzc;
    logic [2:0]  i_tag;
    logic        o_valid;
    logic        o_sign;
    logic [14:0] o_exp;
    logic [47:0] o_coef;
    logic [2:0]  o_tag;
    logic        o_zero;
    logic        o_uflow;
    logic        o_oflow;

    float_add_norm u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sign  (i_sign),
        .i_exp   (i_exp),
        .i_carry (i_carry),
        .i_coef  (i_coef),
        .i_lzc   (i_lzc),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .o_sign  (o_sign),
        .o_exp   (o_exp),
        .o_coef  (o_coef),
        .o_tag   (o_tag),
        .o_zero  (o_zero),
        .o_uflow (o_uflow),
        .o_oflow (o_oflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        sign;
        logic [14:0] exp;
        logic [47:0] coef;
        logic [2:0]  tag;
        logic        zero;
        logic        uflow;
        logic        oflow;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic [14:0] e, input logic [47:0] c,
                                input logic z, input logic uf, input logic of);
        exp_t r;
        r.sign = s; r.exp = e; r.coef = c; r.tag = 3'd0;
        r.zero = z; r.uflow = uf; r.oflow = of; r.cyc = 0;
        return r;
    endfunction

    // Drive one operand; an operand driven while rst is high is dropped.
    task automatic issue(input logic s, input logic [14:0] e, input logic c,
                         input logic [47:0] cf, input logic [6:0] lz,
                         input logic [2:0] t, input logic with_rst, input exp_t ex);
        @(negedge clk);
        rst = with_rst; i_valid = 1'b1; i_sign = s; i_exp = e; i_carry = c;
        i_coef = cf; i_lzc = lz; i_tag = t;
        if (!with_rst) begin
            ex.tag = t;
            ex.cyc = cyc;
            sb_q.push_back(ex);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_valid"}, 64'(o_valid), 64'd0);
        check({tagname, "_sign"},  64'(o_sign),  64'd0);
        check({tagname, "_exp"},   64'(o_exp),   64'd0);
        check({tagname, "_coef"},  64'(o_coef),  64'd0);
        check({tagname, "_tag"},   64'(o_tag),   64'd0);
        check({tagname, "_zero"},  64'(o_zero),  64'd0);
        check({tagname, "_uflow"}, 64'(o_uflow), 64'd0);
        check({tagname, "_oflow"}, 64'(o_oflow), 64'd0);
    endtask

    // Monitor: every presented result must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_o_valid", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("tag",     64'(o_tag),   64'(e.tag));
                    check("latency", 64'(cyc - e.cyc), 64'd2);
                    check("sign",    64'(o_sign),  64'(e.sign));
                    check("exp",     64'(o_exp),   64'(e.exp));
                    check("coef",    64'(o_coef),  64'(e.coef));
                    check("zero",    64'(o_zero),  64'(e.zero));
                    check("uflow",   64'(o_uflow), 64'(e.uflow));
                    check("oflow",   64'(o_oflow), 64'(e.oflow));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    exp_t uf5;
    exp_t uf7;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_carry = 1'b0;
        i_coef = '0; i_lzc = '0; i_tag = '0;
`ifdef FLOAT_NORM_UFLOW_FLUSH_EN
        uf5 = mk(1'b0, 15'o0, 48'h0, 1'b1, 1'b1, 1'b0);
        uf7 = mk(1'b0, 15'o0, 48'h0, 1'b1, 1'b1, 1'b0);
`else
        uf5 = mk(1'b1, 15'o17777, 48'h800000000000, 1'b0, 1'b1, 1'b0);
        uf7 = mk(1'b0, 15'o77771, 48'hFFFFFFFFFC00, 1'b0, 1'b1, 1'b0);
`endif
        // Operand presented during reset is dropped.
        issue(1'b1, 15'o40000, 1'b0, 48'h1, 7'd47, 3'd7, 1'b1, mk(0, 0, 0, 0, 0, 0));
        repeat (3) idle();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed vectors, back to back.
        issue(0, 15'o40060, 0, 48'h000000000001, 7'd47, 3'd1, 0, mk(0, 15'o40001, 48'h800000000000, 0, 0, 0));
        issue(0, 15'o40000, 1, 48'h000000000003, 7'd33, 3'd2, 0, mk(0, 15'o40001, 48'h800000000001, 0, 0, 0));
        issue(1, 15'o40000, 0, 48'h000000000000, 7'd48, 3'd3, 0, mk(0, 15'o0, 48'h0, 1, 0, 0));
        issue(1, 15'o40000, 0, 48'h000000000123, 7'd127, 3'd4, 0, mk(0, 15'o0, 48'h0, 1, 0, 0));
        issue(1, 15'o20005, 0, 48'h020000000000, 7'd6, 3'd5, 0, uf5);
        issue(0, 15'o57777, 1, 48'h800000000000, 7'd0, 3'd6, 0, mk(0, 15'o60000, 48'hC00000000000, 0, 0, 1));
        issue(0, 15'o00003, 0, 48'h003FFFFFFFFF, 7'd10, 3'd7, 0, uf7);
        issue(0, 15'o20003, 0, 48'h100000000000, 7'd3, 3'd0, 0, mk(0, 15'o20000, 48'h800000000000, 0, 0, 0));
        issue(0, 15'o57777, 0, 48'h800000000000, 7'd0, 3'd1, 0, mk(0, 15'o57777, 48'h800000000000, 0, 0, 0));
        issue(0, 15'o60005, 0, 48'h040000000000, 7'd5, 3'd2, 0, mk(0, 15'o60000, 48'h800000000000, 0, 0, 1));
        issue(0, 15'o77777, 1, 48'h000000000000, 7'd0, 3'd3, 0, mk(0, 15'o0, 48'h800000000000, 0, 0, 1));
        issue(1, 15'o40100, 0, 48'h0007FFFFFFFF, 7'd13, 3'd4, 0, mk(1, 15'o40063, 48'hFFFFFFFFE000, 0, 0, 0));
        issue(0, 15'o40000, 0, 48'h8A5A5A5A5A5A, 7'd0, 3'd5, 0, mk(0, 15'o40000, 48'h8A5A5A5A5A5A, 0, 0, 0));
        issue(0, 15'o40050, 0, 48'h0000000000AB, 7'd40, 3'd6, 0, mk(0, 15'o40000, 48'hAB0000000000, 0, 0, 0));

        // Bubble: o_valid drops, data holds the last result.
        repeat (3) idle();
        check("bubble_valid", 64'(o_valid), 64'd0);
        check("bubble_coef_hold", 64'(o_coef), 64'hAB0000000000);
        check("bubble_exp_hold", 64'(o_exp), 64'(15'o40000));
        check("bubble_tag_hold", 64'(o_tag), 64'd6);
        check("drain1_empty", 64'(sb_q.size()), 64'd0);

        // Reset mid-stream: tag 1 in flight and tag 2 during rst both vanish.
        issue(0, 15'o40060, 0, 48'h000000000001, 7'd47, 3'd1, 0, mk(0, 15'o40001, 48'h800000000000, 0, 0, 0));
        issue(0, 15'o40000, 1, 48'h000000000003, 7'd0, 3'd2, 1, mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        sb_q.delete();
        check_reset_outputs("midreset");
        rst = 1'b0; i_valid = 1'b1; i_sign = 1'b0; i_exp = 15'o40000; i_carry = 1'b0;
        i_coef = 48'h8A5A5A5A5A5A; i_lzc = 7'd0; i_tag = 3'd3;
        begin
            exp_t e3;
            e3 = mk(0, 15'o40000, 48'h8A5A5A5A5A5A, 0, 0, 0);
            e3.tag = 3'd3;
            e3.cyc = cyc;
            sb_q.push_back(e3);
        end
        idle();

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/float_add_norm.md
# float_add_norm

Post-add renormalization stage for the scalar/vector floating-point adder. It takes the raw 48-bit coefficient sum with its carry-out, the exponent and the leading-zero count from the adder's LZ unit, and applies the normalizing shift and exponent correction. Outputs are the packed-ready sign, exponent and coefficient plus range flags, through a fixed two-stage pipeline with no backpressure, matching the functional-unit timing model. It sits between the coefficient adder plus LZ count and the result write-back to S/V registers.

## Interface
- EXP_W, 15, exponent width (biased, 0o40000 bias)
- UFLOW_LIM, 15'o20000, results with exponent below this are underflow
- OFLOW_LIM, 15'o60000, results with exponent at/above this are overflow
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  operand present this cycle
- i_sign  in  1  result sign from adder
- i_exp  in  EXP_W  larger operand's exponent (pre-normalize)
- i_carry  in  1  carry-out of 48-bit coefficient add
- i_coef  in  48  raw coefficient sum bits [47:0]
- i_lzc  in  7  leading-zero count of i_coef, 0..48
- i_tag  in  3  destination register tag, passed through
- o_valid  out  1  result valid
- o_sign, o_exp[EXP_W-1:0], o_coef[47:0], o_tag[2:0]  out  normalized result
- o_zero  out  1  result is true zero
- o_uflow  out  1  exponent underflow
- o_oflow  out  1  exponent overflow

## Operation
- Carry path (i_carry=1): coef = {1, i_coef[47:1]}, exp = i_exp + 1; i_lzc ignored.
- Normal path (i_carry=0, i_lzc<48): coef = i_coef << i_lzc, exp = i_exp - i_lzc.
- Zero path (i_carry=0, i_lzc>=48, any value 48..127): o_zero=1, o_sign=0, o_exp=0, o_coef=0, no flags.
- Exponent math done in EXP_W+1 bits: borrow (negative) or result < UFLOW_LIM -> o_uflow; result >= OFLOW_LIM or carry past EXP_W bits -> o_oflow. At most one of uflow/oflow set; zero path sets neither.
- Overflow: value passed as computed (exp truncated to EXP_W), flag only.
- Underflow handling per Configuration.
- Stage 1: select carry/normal/zero path, coarse left shift by i_lzc[5:3]*8, register exponent and i_lzc[2:0], tag, sign, valid.
- Stage 2: fine shift by lzc[2:0], exponent subtract/increment, range compare, flag generation, output register.
- Pipeline stage data registers load only when that stage's valid is 1; hold otherwise. Valid bits shift every cycle.

## Timing
- Latency exactly 2: i_valid at edge N -> o_valid at edge N+2 with that operand's result.
- Throughput one result per cycle; back-to-back issues are never merged, dropped or reordered.
- No ready/stall; the issuer guarantees the write-back slot.
- Reset: rst high at an edge clears both stage valids and all output registers (o_valid, o_sign, o_exp, o_coef, o_tag, o_zero, o_uflow, o_oflow = 0). In-flight operands are discarded. An operand with i_valid=1 during rst is dropped. First post-reset result appears 2 cycles after the first accepted i_valid.
- Bubble (i_valid=0): o_valid=0 two cycles later, output data holds previous value.

## Configuration
- FLOAT_NORM_UFLOW_FLUSH_EN defined: underflowed results flush to o_sign=0, o_exp=0, o_coef=0, o_zero=1, with o_uflow still 1.
- Undefined: underflowed result passed through with the computed exponent truncated to EXP_W, o_zero=0, o_uflow=1.

## Test plan
- Normal: i_coef=0x000000000001, i_lzc=47, i_exp=0o40060, i_carry=0 -> 2 cycles later o_coef=0x800000000000, o_exp=0o40001, flags 0.
- Carry: i_carry=1, i_coef=0x000000000003, i_exp=0o40000 -> o_coef=0x800000000001, o_exp=0o40001.
- Zero: i_coef=0, i_lzc=48, i_sign=1 -> o_zero=1, o_sign=0, o_exp=0, o_coef=0, o_uflow=o_oflow=0.
- Underflow: i_exp=0o20005, i_lzc=6, i_coef=0x020000000000 -> o_uflow=1. Flush build: all-zero with o_zero=1. Non-flush build: o_exp=0o17777, o_coef=0x800000000000.
- Overflow: i_carry=1, i_exp=0o57777 -> o_exp=0o60000, o_oflow=1.
- Streaming/reset: three consecutive valids with tags 1,2,3 -> outputs on cycles N+2..N+4 in order. Repeat with rst asserted at N+1 -> no o_valid for tags 1,2. Tag 3 issued the cycle after rst deasserts emerges 2 cycles later.
